neuron_accumulator: RTL

//  Downstream consumer of the 5x5 sign-magnitude multiplier. Takes N_INPUTS
//  10-bit sign-magnitude products (bit9 sign, bits8:0 magnitude) for one neuron
//  and accumulates them in two's complement. Adds a bias, then applies ReLU,

---
 rtl/neuron_accumulator.sv | 106 ++++++++++
 1 files changed

// File: rtl/neuron_accumulator.sv
// Accumulates N_INPUTS sign-magnitude products for one neuron, adds a bias, then
// applies ReLU, scaling and saturation to form a 5-bit sign-magnitude activation.
module neuron_accumulator #(
    parameter int N_INPUTS = 4,
    parameter int ACC_W    = 16,
    parameter int SHIFT    = 4,
    parameter int RELU     = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [9:0]              in_prod,
    input  logic signed [ACC_W-1:0] bias,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [4:0]              out_act,
    output logic signed [ACC_W-1:0] out_acc,
    output logic                    out_sat
);

    localparam int CNT_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_INPUTS - 1);

    typedef enum logic {ACCUM, OUTPUT} state_t;

    state_t                  state, state_nx;
    logic signed [ACC_W-1:0] acc;
    logic [CNT_W-1:0]        cnt;
    logic signed [ACC_W-1:0] prod;
    logic signed [ACC_W-1:0] sum;
    logic [ACC_W-1:0]        mag_full;
    logic [ACC_W-1:0]        shifted;
    logic                    neg;
    logic [3:0]              mag;
    logic [4:0]              act;
    logic                    act_sat;
    logic                    beat;
    logic                    last;

    // Product decode and the activation of the would-be final sum.
    // Negative zero decodes to -0 == 0, so it needs no special case.
    always_comb begin
        prod     = in_prod[9] ? -$signed(ACC_W'(in_prod[8:0])) : $signed(ACC_W'(in_prod[8:0]));
        sum      = acc + prod + bias;
        neg      = sum[ACC_W-1];
        mag_full = neg ? $unsigned(-sum) : $unsigned(sum);
        shifted  = mag_full >> SHIFT;
        mag      = shifted[3:0];
        act_sat  = 1'b0;
        if (shifted > ACC_W'(15)) begin
            mag     = 4'hF;
            act_sat = 1'b1;
        end
        act = {neg && (mag != 4'd0), mag};
        if (neg && (RELU != 0)) begin
            act     = 5'd0;
            act_sat = 1'b0;
        end
    end

    // Handshake and next-state logic; clear overrides everything.
    always_comb begin
        state_nx  = state;
        in_ready  = (state == ACCUM);
        out_valid = (state == OUTPUT);
        last      = (cnt == LAST_CNT);
        beat      = in_valid && (state == ACCUM) && !clear;
        case (state)
            ACCUM:  if (beat && last) state_nx = OUTPUT;
            OUTPUT: if (out_ready)    state_nx = ACCUM;
            default:                  state_nx = ACCUM;
        endcase
        if (clear) state_nx = ACCUM;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ACCUM;
            acc     <= '0;
            cnt     <= '0;
            out_act <= 5'd0;
            out_acc <= '0;
            out_sat <= 1'b0;
        end else begin
            state <= state_nx;
            if (clear) begin
                acc <= '0;
                cnt <= '0;
            end else if (beat) begin
                if (last) begin
                    out_acc <= sum;
                    out_act <= act;
                    out_sat <= act_sat;
                    acc     <= '0;
                    cnt     <= '0;
                end else begin
                    acc <= acc + prod;
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule
